// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, lock tag constants and FSM encoding for the fetch controller.
package fetch_ctrl_pkg;

    localparam int INST_ADDR_WIDTH = 32;
    localparam int REG_LOCK_WIDTH  = 4;
    localparam logic [REG_LOCK_WIDTH-1:0] REG_NO_LOCK = 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_RESP   = 3'd2,
        ST_DELIV  = 3'd3,
        ST_LOCKED = 3'd4,
        ST_DRAIN  = 3'd5
    } fetch_state_e;

    function automatic logic [INST_ADDR_WIDTH-1:0] pc_add(
        input logic [INST_ADDR_WIDTH-1:0] base,
        input logic [INST_ADDR_WIDTH-1:0] delta
    );
        return base + delta;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding icache request, decoder hand-off,
// CDB-resolved next-pc locking and ROB redirect. FETCH_CTRL_PERF_EN adds perf counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       ic_req,
    output logic [INST_ADDR_WIDTH-1:0] ic_addr,
    input  logic                       ic_ready,
    input  logic                       ic_valid,
    input  logic [31:0]                ic_data,
    output logic                       dec_valid,
    output logic [31:0]                dec_inst,
    output logic [INST_ADDR_WIDTH-1:0] dec_pc,
    input  logic                       dec_ready,
    input  logic [REG_LOCK_WIDTH-1:0]  dec_lock,
    input  logic [INST_ADDR_WIDTH-1:0] dec_offset,
    input  logic [REG_LOCK_WIDTH-1:0]  cdb_index,
    input  logic [INST_ADDR_WIDTH-1:0] cdb_result,
    input  logic                       rob_modify,
    input  logic [INST_ADDR_WIDTH-1:0] rob_npc,
    input  logic                       stall,
`ifdef FETCH_CTRL_PERF_EN
    output logic                       pc_locked,
    output logic [31:0]                perf_fetch_cnt,
    output logic [31:0]                perf_lock_cnt
`else
    output logic                       pc_locked
`endif
);

    fetch_state_e                 state_r;
    fetch_state_e                 state_next_s;
    logic [INST_ADDR_WIDTH-1:0]   pc_r;
    logic [INST_ADDR_WIDTH-1:0]   pc_next_s;
    logic [REG_LOCK_WIDTH-1:0]    lock_r;
    logic [REG_LOCK_WIDTH-1:0]    lock_next_s;
    logic                         capture_s;
    logic                         ic_req_r;
    logic                         dec_valid_r;
    logic                         pc_locked_r;
    logic [31:0]                  dec_inst_r;
    logic [INST_ADDR_WIDTH-1:0]   dec_pc_r;

    assign ic_req    = ic_req_r;
    assign ic_addr   = pc_r;
    assign dec_valid = dec_valid_r;
    assign dec_inst  = dec_inst_r;
    assign dec_pc    = dec_pc_r;
    assign pc_locked = pc_locked_r;

    // Next-state, next-pc and lock tag; a ROB redirect outranks every other event outside IDLE.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        lock_next_s  = lock_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_REQ;
            end
            ST_REQ: begin
                if (rob_modify) begin
                    pc_next_s    = rob_npc;
                    lock_next_s  = REG_NO_LOCK;
                    state_next_s = ic_ready ? ST_DRAIN : ST_REQ;
                end else if (ic_ready) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RESP: begin
                if (rob_modify) begin
                    pc_next_s    = rob_npc;
                    lock_next_s  = REG_NO_LOCK;
                    state_next_s = ic_valid ? ST_REQ : ST_DRAIN;
                end else if (ic_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_DELIV;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            ST_DELIV: begin
                if (rob_modify) begin
                    pc_next_s    = rob_npc;
                    lock_next_s  = REG_NO_LOCK;
                    state_next_s = ST_REQ;
                end else if (dec_ready && !stall) begin
                    if (dec_lock == REG_NO_LOCK) begin
                        pc_next_s    = pc_add(pc_r, dec_offset);
                        state_next_s = ST_REQ;
                    end else begin
                        lock_next_s  = dec_lock;
                        state_next_s = ST_LOCKED;
                    end
                end else begin
                    state_next_s = ST_DELIV;
                end
            end
            ST_LOCKED: begin
                if (rob_modify) begin
                    pc_next_s    = rob_npc;
                    lock_next_s  = REG_NO_LOCK;
                    state_next_s = ST_REQ;
                end else if (cdb_index == lock_r) begin
                    pc_next_s    = pc_add(pc_r, cdb_result);
                    lock_next_s  = REG_NO_LOCK;
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            ST_DRAIN: begin
                // The stale response still has to come back before a new request may go out.
                if (rob_modify) begin
                    pc_next_s   = rob_npc;
                    lock_next_s = REG_NO_LOCK;
                end else begin
                    pc_next_s   = pc_r;
                end
                state_next_s = ic_valid ? ST_REQ : ST_DRAIN;
            end
            default: begin
                state_next_s = ST_IDLE;
                pc_next_s    = {INST_ADDR_WIDTH{1'b0}};
                lock_next_s  = REG_NO_LOCK;
            end
        endcase
    end

    // State, pc, lock tag and registered output decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= {INST_ADDR_WIDTH{1'b0}};
            lock_r      <= REG_NO_LOCK;
            ic_req_r    <= 1'b0;
            dec_valid_r <= 1'b0;
            pc_locked_r <= 1'b0;
            dec_inst_r  <= 32'd0;
            dec_pc_r    <= {INST_ADDR_WIDTH{1'b0}};
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            lock_r      <= lock_next_s;
            ic_req_r    <= (state_next_s == ST_REQ);
            dec_valid_r <= (state_next_s == ST_DELIV);
            pc_locked_r <= (state_next_s == ST_LOCKED);
            if (capture_s) begin
                dec_inst_r <= ic_data;
                dec_pc_r   <= pc_r;
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_lock_r;

    assign perf_fetch_cnt = perf_fetch_r;
    assign perf_lock_cnt  = perf_lock_r;

    // Free-running wrap-around counters of consumed instructions and locked cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_r <= 32'd0;
            perf_lock_r  <= 32'd0;
        end else begin
            if ((state_r == ST_DELIV) && dec_ready && !stall && !rob_modify) begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end
            if (state_r == ST_LOCKED) begin
                perf_lock_r <= perf_lock_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then randomized traffic against a transaction-level model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       ic_req;
    logic [INST_ADDR_WIDTH-1:0] ic_addr;
    logic                       ic_ready = 1'b0;
    logic                       ic_valid = 1'b0;
    logic [31:0]                ic_data = 32'd0;
    logic                       dec_valid;
    logic [31:0]                dec_inst;
    logic [INST_ADDR_WIDTH-1:0] dec_pc;
    logic                       dec_ready = 1'b0;
    logic [REG_LOCK_WIDTH-1:0]  dec_lock = 4'd0;
    logic [INST_ADDR_WIDTH-1:0] dec_offset = 32'd0;
    logic [REG_LOCK_WIDTH-1:0]  cdb_index = 4'd0;
    logic [INST_ADDR_WIDTH-1:0] cdb_result = 32'd0;
    logic                       rob_modify = 1'b0;
    logic [INST_ADDR_WIDTH-1:0] rob_npc = 32'd0;
    logic                       stall = 1'b0;
    logic                       pc_locked;

    fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready),
        .ic_valid(ic_valid), .ic_data(ic_data),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_ready(dec_ready), .dec_lock(dec_lock), .dec_offset(dec_offset),
        .cdb_index(cdb_index), .cdb_result(cdb_result),
        .rob_modify(rob_modify), .rob_npc(rob_npc),
        .stall(stall), .pc_locked(pc_locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the fetch unit owes the outside world, tracked per transaction.
    bit                        m_started, m_out, m_disc, m_have;
    logic [31:0]               m_pc, m_inst, m_inst_pc;
    logic [REG_LOCK_WIDTH-1:0] m_lock;

    // Icache responder: one response per accepted request after lat cycles.
    bit          c_busy;
    int          c_cnt;
    int          lat = 1;
    logic [31:0] fetch_log[$];
    logic [31:0] saved_inst;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_out = 1'b0; m_disc = 1'b0; m_have = 1'b0;
        m_pc = 32'd0; m_inst = 32'd0; m_inst_pc = 32'd0; m_lock = 4'd0;
        c_busy = 1'b0; c_cnt = 0;
    endtask

    function automatic bit exp_req();
        return m_started && !m_out && !m_have && (m_lock == 4'd0);
    endfunction

    task automatic check_outputs();
        check_eq("ic_req", 32'(ic_req), 32'(exp_req()));
        if (exp_req()) check_eq("ic_addr", ic_addr, m_pc);
        check_eq("dec_valid", 32'(dec_valid), 32'(m_have));
        if (m_have) begin
            check_eq("dec_inst", dec_inst, m_inst);
            check_eq("dec_pc", dec_pc, m_inst_pc);
        end
        check_eq("pc_locked", 32'(pc_locked), 32'(m_lock != 4'd0));
    endtask

    task automatic model_step();
        bit                        req_prev  = exp_req();
        bit                        out_prev  = m_out;
        bit                        have_prev = m_have;
        logic [REG_LOCK_WIDTH-1:0] lock_prev = m_lock;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (rob_modify) begin
            m_pc = rob_npc; m_lock = 4'd0; m_have = 1'b0;
            if (out_prev && ic_valid) m_out = 1'b0;
            if (req_prev && ic_ready) m_out = 1'b1;
            m_disc = m_out;
        end else begin
            if (out_prev && ic_valid) begin
                m_out = 1'b0;
                if (!m_disc) begin
                    m_have = 1'b1; m_inst = ic_data; m_inst_pc = m_pc;
                end
                m_disc = 1'b0;
            end
            if (req_prev && ic_ready) begin
                m_out = 1'b1; m_disc = 1'b0;
            end
            if (have_prev && dec_ready && !stall) begin
                m_have = 1'b0;
                if (dec_lock == 4'd0) m_pc = m_pc + dec_offset;
                else m_lock = dec_lock;
            end
            if (lock_prev != 4'd0 && cdb_index == lock_prev) begin
                m_pc = m_pc + cdb_result; m_lock = 4'd0;
            end
        end
    endtask

    // One clock: drive icache response, advance the model, then check after the edge.
    task automatic cycle();
        bit accept;
        ic_valid = c_busy && (c_cnt == 0);
        ic_data  = $urandom;
        model_step();
        accept = ic_req && ic_ready;
        if (accept) fetch_log.push_back(ic_addr);
        if (ic_valid) c_busy = 1'b0;
        else if (c_busy) c_cnt--;
        if (accept) begin
            c_busy = 1'b1; c_cnt = lat - 1;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_req(input int bound, input string tag);
        int k = 0;
        while (!ic_req && k < bound) begin
            cycle();
            check_eq({tag, "_no_dec"}, 32'(dec_valid), 32'd0);
            k++;
        end
        check_eq({tag, "_req_seen"}, 32'(ic_req), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_ic_req", 32'(ic_req), 32'd0);
        check_eq("rst_ic_addr", ic_addr, 32'd0);
        check_eq("rst_dec_valid", 32'(dec_valid), 32'd0);
        check_eq("rst_dec_inst", dec_inst, 32'd0);
        check_eq("rst_dec_pc", dec_pc, 32'd0);
        check_eq("rst_pc_locked", 32'(pc_locked), 32'd0);
        rst_n = 1'b1;
        check_outputs();

        // Straight-line fetch: addresses 0x0, 0x4, 0x8.
        ic_ready = 1'b1; dec_ready = 1'b1; dec_offset = 32'd4; lat = 1;
        for (int k = 0; k < 30 && fetch_log.size() < 3; k++) cycle();
        check_eq("seq_len", 32'(fetch_log.size()), 32'd3);
        if (fetch_log.size() >= 3) begin
            check_eq("seq_0", fetch_log[0], 32'h0);
            check_eq("seq_1", fetch_log[1], 32'h4);
            check_eq("seq_2", fetch_log[2], 32'h8);
        end

        // Locked next-pc; a CDB hit in the capture cycle is ignored.
        dec_lock = 4'd5; cdb_index = 4'd5; cdb_result = 32'h20;
        cycle();
        cycle();
        dec_lock = 4'd0;
        check_eq("lock_pc_locked", 32'(pc_locked), 32'd1);
        check_eq("lock_no_req", 32'(ic_req), 32'd0);
        cdb_index = 4'd3;
        repeat (2) cycle();
        check_eq("lock_wrong_tag", 32'(pc_locked), 32'd1);
        check_eq("lock_wrong_tag_req", 32'(ic_req), 32'd0);
        cdb_index = 4'd5;
        cycle();
        cdb_index = 4'd0;
        check_eq("unlock_req", 32'(ic_req), 32'd1);
        check_eq("unlock_addr", ic_addr, 32'h28);

        // Redirect while waiting for a response: drain, drop the data, refetch at 0x100.
        lat = 3;
        cycle();
        rob_modify = 1'b1; rob_npc = 32'h100;
        cycle();
        rob_modify = 1'b0;
        check_eq("drain_no_req", 32'(ic_req), 32'd0);
        run_until_req(10, "drain");
        check_eq("drain_addr", ic_addr, 32'h100);

        // Stall holds the decoder view for three cycles.
        lat = 1;
        cycle();
        cycle();
        saved_inst = dec_inst;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("stall_valid", 32'(dec_valid), 32'd1);
            check_eq("stall_inst", dec_inst, saved_inst);
            check_eq("stall_no_req", 32'(ic_req), 32'd0);
        end
        stall = 1'b0;
        cycle();
        check_eq("stall_release_addr", ic_addr, 32'h104);

        // pc wrap-around.
        ic_ready = 1'b0; rob_modify = 1'b1; rob_npc = 32'hFFFF_FFFC;
        cycle();
        rob_modify = 1'b0; ic_ready = 1'b1; dec_offset = 32'd8;
        cycle();
        cycle();
        check_eq("wrap_dec_pc", dec_pc, 32'hFFFF_FFFC);
        cycle();
        check_eq("wrap_addr", ic_addr, 32'h4);

        // Asynchronous reset while locked.
        dec_offset = 32'd4; dec_lock = 4'd7;
        repeat (3) cycle();
        dec_lock = 4'd0;
        check_eq("prerst_locked", 32'(pc_locked), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_ic_req", 32'(ic_req), 32'd0);
        check_eq("arst_ic_addr", ic_addr, 32'd0);
        check_eq("arst_dec_valid", 32'(dec_valid), 32'd0);
        check_eq("arst_dec_inst", dec_inst, 32'd0);
        check_eq("arst_dec_pc", dec_pc, 32'd0);
        check_eq("arst_pc_locked", 32'(pc_locked), 32'd0);
        model_reset();
        ic_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_until_req(5, "restart");
        check_eq("restart_addr", ic_addr, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            ic_ready   = ($urandom_range(0, 3) != 0);
            lat        = int'($urandom_range(1, 3));
            dec_ready  = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            dec_lock   = ($urandom_range(0, 2) == 0) ? REG_LOCK_WIDTH'($urandom_range(1, 15)) : 4'd0;
            dec_offset = ($urandom_range(0, 9) == 0) ? 32'($urandom) : (32'($urandom_range(0, 63)) << 2);
            cdb_index  = ($urandom_range(0, 2) == 0 && m_lock != 4'd0) ? m_lock
                                                                       : REG_LOCK_WIDTH'($urandom_range(0, 15));
            cdb_result = $urandom;
            rob_modify = ($urandom_range(0, 19) == 0);
            rob_npc    = $urandom & 32'hFFFF_FFFC;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 ic_req  out  1  fetch request to icache; held until accepted.
REQ-004 ic_addr  out  `Inst_Addr_Width  fetch address; equals internal pc while ic_req=1.
REQ-005 ic_ready  in  1  icache accepts request this cycle when ic_req=1.
REQ-006 ic_valid / ic_data  in  1 / 32  instruction return, one cycle pulse per accepted request.
REQ-007 dec_valid / dec_inst / dec_pc  out  1 / 32 / `Inst_Addr_Width  instruction presented to decoder.
REQ-008 dec_ready  in  1  decoder consumes instruction; handshake = dec_valid & dec_ready & !stall.
REQ-009 dec_lock / dec_offset  in  `Reg_Lock_Width / `Inst_Addr_Width  next-pc info for the handshaken instruction, valid in handshake cycle.
REQ-010 cdb_index / cdb_result  in  `Reg_Lock_Width / `Inst_Addr_Width  broadcast tag and resolved offset.
REQ-011 rob_modify / rob_npc  in  1 / `Inst_Addr_Width  mispredict redirect.
REQ-012 stall  in  1  global stall; blocks decoder handshake only.
REQ-013 pc_locked  out  1  high while waiting on a CDB tag.

Function
REQ-014 States: IDLE, REQ, RESP, DELIV, LOCKED, DRAIN; one-hot or binary encoding free.
REQ-015 IDLE -> REQ unconditionally one cycle after reset release; pc=0.
REQ-016 REQ: ic_req=1, ic_addr=pc; ic_ready=1 -> RESP.
REQ-017 RESP: ic_valid=1 -> capture ic_data into dec_inst, pc into dec_pc, -> DELIV.
REQ-018 DELIV: dec_valid=1; on handshake with dec_lock==`Reg_No_Lock: pc <= pc+dec_offset (mod 2^32), -> REQ.
REQ-019 DELIV handshake with dec_lock!=`Reg_No_Lock: lock_reg <= dec_lock, -> LOCKED.
REQ-020 LOCKED: pc_locked=1; cdb_index==lock_reg: pc <= pc+cdb_result, lock_reg <= `Reg_No_Lock, -> REQ.
REQ-021 Exactly one outstanding icache request; ic_req never asserted outside REQ.
REQ-022 rob_modify has priority over every other event in every state except IDLE: pc <= rob_npc, lock_reg cleared, dec_valid deasserted next cycle.
REQ-023 rob_modify in RESP without ic_valid, or in REQ with ic_ready=1 same cycle: -> DRAIN; else -> REQ.
REQ-024 rob_modify in RESP with ic_valid=1 same cycle: response discarded, -> REQ.
REQ-025 DRAIN: ignore ic_valid data, -> REQ on ic_valid; further rob_modify updates pc, stays DRAIN.
REQ-026 stall=1 holds DELIV with dec_valid/dec_inst/dec_pc stable; stall does not block REQ, RESP, LOCKED, DRAIN.
REQ-027 CDB match in the same cycle lock is captured (DELIV) is not honoured; tag compared from LOCKED only.
REQ-028 Minimum latency pc-update -> next ic_req: 1 cycle.

Reset
REQ-029 rst_n=0 asynchronously: state=IDLE, pc=0, lock_reg=`Reg_No_Lock, ic_req=0, ic_addr=0, dec_valid=0, dec_inst=0, dec_pc=0, pc_locked=0.
REQ-030 Reset mid-transaction abandons in-flight icache request; a late ic_valid after reset release in IDLE/REQ is ignored.

Configuration
REQ-031 Macro FETCH_CTRL_PERF_EN defined: adds outputs perf_fetch_cnt (32, increments per decoder handshake) and perf_lock_cnt (32, increments per cycle in LOCKED), both wrap, reset to 0.
REQ-032 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-033 `Inst_Addr_Width, `Reg_Lock_Width, `Reg_No_Lock and state encodings live in defines.v; no local redefinition.
REQ-034 Single module; optional sub-module fetch_perf_cnt holds the REQ-031 counters.

Verification
REQ-035 Reset release, ic_ready=1, ic_valid next cycle, dec_ready=1, dec_offset=4 -> ic_addr sequence 0x0,0x4,0x8.
REQ-036 Handshake with dec_lock=5 -> pc_locked=1, no ic_req; cdb_index=3 no effect; cdb_index=5, cdb_result=0x20 at pc=0x8 -> next ic_addr=0x28.
REQ-037 rob_modify=1, rob_npc=0x100 in RESP -> DRAIN, next ic_valid data not presented, next ic_addr=0x100.
REQ-038 stall=1 for 3 cycles in DELIV with dec_ready=1 -> dec_valid/dec_inst stable, no pc change, advance after stall drops.
REQ-039 pc=0xFFFFFFFC, dec_offset=8 -> next ic_addr=0x4 (wrap).
REQ-040 rst_n low in LOCKED -> all outputs zero immediately; fetch restarts at 0x0.
